cnn_layer_sequencer: RTL and testbench

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_layer_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - AHB-programmed CNN layer frame sequencer
// Walks VSYNC/HSYNC/DATA timing per layer and optionally chains through layer descriptors.
module cnn_layer_sequencer #(
   parameter int W_ADDR         = 32,
   parameter int W_DATA         = 32,
   parameter int W_SIZE         = 12,
   parameter int W_DELAY        = 12,
   parameter int N_LAYER        = 8,
   parameter int WIDTH          = 128,
   parameter int HEIGHT         = 128,
   parameter int START_UP_DELAY = 200,
   parameter int HSYNC_DELAY    = 160
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       sl_HSEL,
   input  logic                       sl_HREADY,
   input  logic [1:0]                 sl_HTRANS,
   input  logic [W_ADDR-1:0]          sl_HADDR,
   input  logic                       sl_HWRITE,
   input  logic [W_DATA-1:0]          sl_HWDATA,
   output logic                       out_sl_HREADY,
   output logic [1:0]                 out_sl_HRESP,
   output logic [W_DATA-1:0]          out_sl_HRDATA,
   output logic                       o_ctrl_data_run,
   output logic [W_SIZE-1:0]          o_row,
   output logic [W_SIZE-1:0]          o_col,
   output logic [$clog2(N_LAYER)-1:0] o_layer_idx,
   output logic [9:0]                 o_layer_cfg,
   output logic                       o_layer_start,
   output logic                       o_irq
);

   localparam int               W_LI    = $clog2(N_LAYER);
   localparam logic [4:0]       C_NL    = 5'(N_LAYER);
   localparam logic [W_DELAY:0] C_D_ONE = 1;
   localparam logic [W_SIZE-1:0] C_S_ONE = 1;
   localparam logic [W_LI-1:0]  C_L_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_LEND} state_t;

   state_t               r_state, w_next;
   logic                 r_wr_pend;
   logic [4:0]           r_idx;
   logic                 r_auto, r_irq_en, r_done;
   logic [W_SIZE-1:0]    r_width, r_height, r_sw, r_sh;
   logic [W_DELAY-1:0]   r_su, r_hs, r_ssu, r_shs, r_cnt;
   logic [4:0]           r_num;
   logic [9:0]           r_cfg [N_LAYER];
   logic [9:0]           r_lcfg;
   logic [W_SIZE-1:0]    r_row, r_col;
   logic [W_LI-1:0]      r_layer;

   logic                 w_sel, w_wr, w_start, w_abort, w_w1c;
   logic [4:0]           w_cfg_off, w_nl_eff;
   logic                 w_cfg_hit;
   logic [W_LI-1:0]      w_cfg_sel, w_layer_nxt;
   logic [W_DELAY-1:0]   w_dly;
   logic                 w_dly_end, w_col_end, w_row_last, w_geo_zero, w_more, w_enter_vs, w_busy;
   logic [31:0]          w_rd;
   logic                 w_unused;

   assign w_unused = ^{sl_HADDR, sl_HWDATA, sl_HTRANS[0]};

   // Address phase is captured here; the write commits one cycle later with HWDATA.
   assign w_sel = sl_HSEL & sl_HREADY & sl_HTRANS[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wr_pend <= 1'b0;
         r_idx     <= 5'd0;
      end else begin
         r_wr_pend <= w_sel & sl_HWRITE;
         if (w_sel) r_idx <= sl_HADDR[6:2];
      end
   end

   assign w_wr      = r_wr_pend;
   assign w_start   = w_wr && (r_idx == 5'd0) && sl_HWDATA[0];
   assign w_abort   = w_wr && (r_idx == 5'd0) && sl_HWDATA[2];
   assign w_w1c     = w_wr && (r_idx == 5'd1) && sl_HWDATA[1];
   assign w_cfg_off = r_idx - 5'd8;
   assign w_cfg_hit = (r_idx >= 5'd8) && (w_cfg_off < C_NL);
   assign w_cfg_sel = w_cfg_off[W_LI-1:0];
   assign w_nl_eff  = (r_num == 5'd0) ? 5'd1 : (r_num > C_NL) ? C_NL : r_num;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
         r_width  <= W_SIZE'(WIDTH);
         r_height <= W_SIZE'(HEIGHT);
         r_su     <= W_DELAY'(START_UP_DELAY);
         r_hs     <= W_DELAY'(HSYNC_DELAY);
         r_num    <= 5'd1;
         for (int k = 0; k < N_LAYER; k++) r_cfg[k] <= 10'd0;
      end else if (w_wr) begin
         case (r_idx)
            5'd0: r_auto <= sl_HWDATA[1];
            5'd2: begin
               r_width  <= sl_HWDATA[W_SIZE-1:0];
               r_height <= sl_HWDATA[16 +: W_SIZE];
            end
            5'd3: begin
               r_su <= sl_HWDATA[W_DELAY-1:0];
               r_hs <= sl_HWDATA[12 +: W_DELAY];
            end
            5'd4: r_num    <= sl_HWDATA[4:0];
            5'd5: r_irq_en <= sl_HWDATA[0];
            default: if (w_cfg_hit) r_cfg[w_cfg_sel] <= sl_HWDATA[9:0];
         endcase
      end
   end

   assign w_busy     = (r_state != S_IDLE);
   assign w_dly      = (r_state == S_VSYNC) ? r_ssu : r_shs;
   assign w_dly_end  = ({1'b0, r_cnt} + C_D_ONE) >= {1'b0, w_dly};
   assign w_col_end  = (r_col == r_sw - C_S_ONE);
   assign w_row_last = (r_row == r_sh - C_S_ONE);
   assign w_geo_zero = (r_sw == '0) || (r_sh == '0);
   assign w_more     = r_auto && (5'(r_layer) < w_nl_eff - 5'd1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_VSYNC;
         S_VSYNC: if (w_dly_end) w_next = w_geo_zero ? S_LEND : S_HSYNC;
         S_HSYNC: if (w_dly_end) w_next = S_DATA;
         S_DATA:  if (w_col_end) w_next = w_row_last ? S_LEND : S_HSYNC;
         S_LEND:  w_next = w_more ? S_VSYNC : S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   assign w_enter_vs  = (w_next == S_VSYNC) && (r_state != S_VSYNC);
   assign w_layer_nxt = (r_state == S_IDLE) ? '0 : r_layer + C_L_ONE;

   // Geometry, delays and the descriptor are frozen at each layer entry.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_layer <= '0;
         r_sw    <= '0;
         r_sh    <= '0;
         r_ssu   <= '0;
         r_shs   <= '0;
         r_lcfg  <= 10'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + W_DELAY'(1);
         r_col   <= (r_state == S_DATA && w_next == S_DATA) ? r_col + C_S_ONE : '0;
         if (w_enter_vs) begin
            r_row   <= '0;
            r_layer <= w_layer_nxt;
            r_sw    <= r_width;
            r_sh    <= r_height;
            r_ssu   <= r_su;
            r_shs   <= r_hs;
            r_lcfg  <= r_cfg[w_layer_nxt];
         end else if (r_state == S_DATA && w_col_end && !w_abort) begin
            r_row <= r_row + C_S_ONE;
         end
         if (r_state == S_LEND && !w_more && !w_abort) r_done <= 1'b1;
         else if (w_w1c) r_done <= 1'b0;
      end
   end

   always_comb begin
      w_rd = 32'd0;
      case (r_idx)
         5'd0: w_rd[1] = r_auto;
         5'd1: begin
            w_rd[0]   = w_busy;
            w_rd[1]   = r_done;
            w_rd[7:4] = 4'(r_layer);
         end
         5'd2: begin
            w_rd[W_SIZE-1:0]   = r_width;
            w_rd[16 +: W_SIZE] = r_height;
         end
         5'd3: begin
            w_rd[W_DELAY-1:0]   = r_su;
            w_rd[12 +: W_DELAY] = r_hs;
         end
         5'd4: w_rd[4:0] = r_num;
         5'd5: w_rd[0]   = r_irq_en;
         default: if (w_cfg_hit) w_rd[9:0] = r_cfg[w_cfg_sel];
      endcase
   end

   assign out_sl_HREADY   = 1'b1;
   assign out_sl_HRESP    = 2'b00;
   assign out_sl_HRDATA   = W_DATA'(w_rd);
   assign o_ctrl_data_run = (r_state == S_DATA);
   assign o_row           = r_row;
   assign o_col           = r_col;
   assign o_layer_idx     = r_layer;
   assign o_layer_cfg     = r_lcfg;
   assign o_layer_start   = (r_state == S_VSYNC) && (r_cnt == '0);
   assign o_irq           = r_done & r_irq_en;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - scoreboard bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;

   localparam int NL = 8;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        sl_HSEL = 1'b0;
   logic        sl_HREADY = 1'b1;
   logic [1:0]  sl_HTRANS = 2'b00;
   logic [31:0] sl_HADDR = 32'd0;
   logic        sl_HWRITE = 1'b0;
   logic [31:0] sl_HWDATA = 32'd0;
   logic        out_sl_HREADY;
   logic [1:0]  out_sl_HRESP;
   logic [31:0] out_sl_HRDATA;
   logic        o_ctrl_data_run;
   logic [11:0] o_row, o_col;
   logic [2:0]  o_layer_idx;
   logic [9:0]  o_layer_cfg;
   logic        o_layer_start, o_irq;

   cnn_layer_sequencer dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY),
      .sl_HTRANS(sl_HTRANS), .sl_HADDR(sl_HADDR), .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
      .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA),
      .o_ctrl_data_run(o_ctrl_data_run), .o_row(o_row), .o_col(o_col),
      .o_layer_idx(o_layer_idx), .o_layer_cfg(o_layer_cfg),
      .o_layer_start(o_layer_start), .o_irq(o_irq)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   typedef struct { int cyc; int layer; int row; int col; int cfg; } pix_t;
   typedef struct { int cyc; int layer; int cfg; } lay_t;
   pix_t pq[$];
   lay_t lq[$];
   int   dq[$];

   int total = 0;
   int bad   = 0;
   int lw[NL], lh[NL], lsu[NL], lhs[NL], lcfg[NL];
   int m_nl, m_auto, t_end;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Reference: every layer is max(su,1) vsync cycles, h rows of (max(hs,1) + w), then one end cycle.
   task automatic push_run(input int t0);
      int t, n;
      t = t0 + 1;
      n = (m_auto == 0 || m_nl == 0) ? 1 : (m_nl > NL) ? NL : m_nl;
      for (int l = 0; l < n; l++) begin
         int s, hh;
         s  = (lsu[l] == 0) ? 1 : lsu[l];
         hh = (lhs[l] == 0) ? 1 : lhs[l];
         lq.push_back('{t, l, lcfg[l]});
         if (lw[l] > 0 && lh[l] > 0) begin
            for (int r = 0; r < lh[l]; r++)
               for (int c = 0; c < lw[l]; c++)
                  pq.push_back('{t + s + r * (hh + lw[l]) + hh + c, l, r, c, lcfg[l]});
            t += s + lh[l] * (hh + lw[l]) + 1;
         end else begin
            t += s + 1;
         end
      end
      dq.push_back(t);
      t_end = t;
   endtask

   task automatic trim(input int a);
      while (pq.size() > 0 && pq[$].cyc > a) void'(pq.pop_back());
      while (lq.size() > 0 && lq[$].cyc > a) void'(lq.pop_back());
      dq.delete();
   endtask

   task automatic ahb_write(input int idx, input int data, output int t_d);
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = idx * 4;
      @(posedge HCLK); #1;
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = data;
      t_d = cyc;
      @(posedge HCLK); #1;
   endtask

   task automatic wr(input int idx, input int data);
      int t;
      ahb_write(idx, data, t);
   endtask

   task automatic ahb_read(input int idx, output int d);
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = idx * 4;
      @(posedge HCLK); #1;
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
      d = out_sl_HRDATA;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) begin @(posedge HCLK); #1; end
   endtask

   task automatic wait_done();
      while (dq.size() > 0 && cyc < t_end + 4) begin @(posedge HCLK); #1; end
      chk("done_seen", dq.size(), 0);
      chk("pixels_left", pq.size(), 0);
      chk("layers_left", lq.size(), 0);
   endtask

   task automatic setup(input int w, input int h, input int su, input int hs, input int nl, input int au);
      m_nl = nl; m_auto = au;
      for (int l = 0; l < NL; l++) begin
         lw[l] = w; lh[l] = h; lsu[l] = su; lhs[l] = hs;
         lcfg[l] = ($urandom_range(0, 127) << 3) | l;
         wr(8 + l, lcfg[l]);
      end
      wr(2, (h << 16) | w);
      wr(3, (hs << 12) | su);
      wr(4, nl);
      wr(1, 2);
   endtask

   task automatic start_run(output int t0);
      ahb_write(0, (m_auto << 1) | 1, t0);
      push_run(t0);
   endtask

   int irq_prev = 0;
   always @(negedge HCLK) begin : monitor
      pix_t p;
      lay_t y;
      int   d;
      if (HRESETn) begin
         if (o_ctrl_data_run) begin
            if (pq.size() == 0) chk("pixel_unexpected", 1, 0);
            else begin
               p = pq.pop_front();
               chk("pix_cycle", cyc, p.cyc);
               chk("pix_layer", o_layer_idx, p.layer);
               chk("pix_row", o_row, p.row);
               chk("pix_col", o_col, p.col);
               chk("pix_cfg", o_layer_cfg, p.cfg);
            end
         end else begin
            chk("col_idle", o_col, 0);
         end
         if (o_layer_start) begin
            if (lq.size() == 0) chk("layer_start_unexpected", 1, 0);
            else begin
               y = lq.pop_front();
               chk("ls_cycle", cyc, y.cyc);
               chk("ls_layer", o_layer_idx, y.layer);
               chk("ls_cfg", o_layer_cfg, y.cfg);
            end
         end
         if (o_irq && irq_prev == 0) begin
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               d = dq.pop_front();
               chk("done_cycle", cyc, d);
            end
         end
      end
      irq_prev = o_irq;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d, a;
      repeat (3) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      chk("rst_run", o_ctrl_data_run, 0);
      chk("rst_row", o_row, 0);
      chk("rst_col", o_col, 0);
      chk("rst_layer", o_layer_idx, 0);
      chk("rst_cfg", o_layer_cfg, 0);
      chk("rst_start", o_layer_start, 0);
      chk("rst_irq", o_irq, 0);
      chk("rst_hready", out_sl_HREADY, 1);
      chk("rst_hresp", out_sl_HRESP, 0);
      chk("rst_rdata0", out_sl_HRDATA, 0);
      ahb_read(2, d); chk("rst_wh", d, 32'h0080_0080);
      ahb_read(3, d); chk("rst_delay", d, 32'h000A_00C8);
      ahb_read(4, d); chk("rst_num_layers", d, 1);
      wr(5, 1);

      // basic frame with a done W1C landing on the LAYER_END cycle
      setup(4, 2, 3, 2, 1, 0);
      start_run(t0);
      wait_until(t0 + 15);
      wr(1, 2);
      chk("irq_set_wins", o_irq, 1);
      ahb_read(1, d); chk("status_done", d, 2);
      wr(1, 2);
      chk("irq_cleared", o_irq, 0);
      wait_done();

      // three chained layers
      setup(3, 1, 0, 0, 3, 1);
      start_run(t0);
      wait_done();
      ahb_read(1, d); chk("status_chain", d, 32'h22);

      // abort in layer 1 row 1, then abort+start together, then a clean restart
      setup(4, 2, 1, 1, 2, 1);
      start_run(t0);
      a = t0 + 21;
      trim(a);
      wait_until(a - 1);
      wr(0, 6);
      chk("abort_run", o_ctrl_data_run, 0);
      ahb_read(1, d); chk("abort_status", d & 3, 0);
      wr(0, 7);
      repeat (6) begin @(posedge HCLK); #1; end
      ahb_read(1, d); chk("abort_wins_busy", d & 1, 0);
      chk("abort_pixels_left", pq.size(), 0);
      chk("abort_layers_left", lq.size(), 0);
      start_run(t0);
      wait_done();

      // start while busy and width change mid-layer
      setup(4, 2, 3, 2, 2, 1);
      for (int l = 1; l < NL; l++) begin lw[l] = 2; lh[l] = 1; end
      start_run(t0);
      wait_until(t0 + 3);
      wr(2, (1 << 16) | 2);
      wr(0, 3);
      wait_done();

      // randomized frames
      for (int i = 0; i < 12; i++) begin
         setup($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 1));
         ahb_read(8 + 3, d); chk("cfg_readback", d, lcfg[3]);
         ahb_read(4, d); chk("num_readback", d, m_nl);
         start_run(t0);
         wait_done();
      end

      // unmapped indices
      wr(7, 32'hFFFF);
      ahb_read(7, d); chk("unmapped7", d, 0);
      ahb_read(6, d); chk("unmapped6", d, 0);
      ahb_read(8 + NL, d); chk("unmapped_cfg", d, 0);

      // reset in the middle of HSYNC
      setup(3, 2, 2, 3, 1, 0);
      start_run(t0);
      wait_until(t0 + 4);
      trim(t0 + 3);
      HRESETn = 1'b0;
      #1;
      chk("mid_rst_run", o_ctrl_data_run, 0);
      chk("mid_rst_row", o_row, 0);
      chk("mid_rst_col", o_col, 0);
      chk("mid_rst_layer", o_layer_idx, 0);
      chk("mid_rst_cfg", o_layer_cfg, 0);
      chk("mid_rst_start", o_layer_start, 0);
      chk("mid_rst_irq", o_irq, 0);
      chk("mid_rst_rdata", out_sl_HRDATA, 0);
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      ahb_read(2, d); chk("post_rst_wh", d, 32'h0080_0080);
      ahb_read(7, d); chk("post_rst_unmapped", d, 0);
      ahb_read(0, d); chk("post_rst_ctrl", d, 0);
      ahb_read(9, d); chk("post_rst_cfg1", d, 0);
      repeat (30) begin @(posedge HCLK); #1; end
      chk("post_rst_irq", o_irq, 0);
      chk("post_rst_pixels", pq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
